pipe_skid_buffer: RTL and testbench
===================================

// Module: pipe_skid_buffer
// PURPOSE
//  Two-entry valid/ready register slice between two pipeline stages.
//  Registers data and control in both directions: no combinational path from m_ready to s_ready.
//  Sustains 1 transfer/cycle. Generates the load enables for its main and skid data registers.
//  Used wherever a stage boundary needs backpressure.
// PARAMETERS
//  WIDTH  32  payload width in bits
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      reset, synchronous, active-high
//  flush      in   1      sync discard of all held entries
//  s_valid    in   1      upstream data valid
//  s_ready    out  1      upstream may transfer (registered)
//  s_data     in   WIDTH  upstream payload
//  m_valid    out  1      downstream data valid (registered)
//  m_ready    in   1      downstream accepts
//  m_data     out  WIDTH  downstream payload (registered, = main reg)
//  occupancy  out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//  - Transfer signals: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
//  - Reset values: m_valid=0, m_data=0, s_ready=1, occupancy=0. Internal: skid reg=0, state=EMPTY.
//  - Priority: rst > flush > normal operation. s_fire/m_fire in a cycle with rst or flush are dropped.
//  - flush: next cycle state=EMPTY, m_valid=0, s_ready=1. Data regs keep their old value (not cleared).
//  - Latency: s_fire at cycle N -> m_valid=1 with that data at N+1. Order is strictly FIFO.
//  - States (2b): EMPTY (occ 0), BUSY (main full, occ 1), FULL (main+skid full, occ 2).
//      EMPTY: s_fire -> BUSY, main<=s_data.
//      BUSY:  s_fire & !m_fire -> FULL, skid<=s_data.
//             !s_fire & m_fire -> EMPTY.
//             s_fire & m_fire  -> BUSY, main<=s_data.
//             neither          -> BUSY, hold.
//      FULL:  m_fire  -> BUSY, main<=skid.
//             !m_fire -> hold.
//             s_ready=0 in FULL, so no s_fire.
//  - Outputs: m_valid = (state!=EMPTY); s_ready = (state!=FULL); both are flop outputs.
//  - Stability: while m_valid & !m_ready, m_data and m_valid do not change. Exception: flush/rst.
//  - No s_data is ever lost or duplicated: every s_fire produces exactly one m_fire, unless flushed.
//  - m_data when m_valid=0: holds the last value, don't-care to consumers.
//  - Illegal state encoding (2'b11) -> EMPTY on next clk.
// STRUCTURE
//  - Shared pipe_pkg:
//      typedef skid_state_e {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}
//      localparam OCC_W=2
//  - Sub-module pipe_skid_ctrl: state FSM only.
//      in:  s_valid, m_ready, flush, rst
//      out: main_ld, skid_ld, sel_skid, m_valid, s_ready, occupancy
//  - Top holds two WIDTH-bit sync-reset, enable-loaded registers (main, skid).
//      main input mux: sel_skid ? skid : s_data.
// TESTING
//  - Reset: rst=1 for 2 clk with s_valid=1, s_data=0xAAAA_AAAA.
//      -> m_valid=0, s_ready=1, occupancy=0, m_data=0 after release.
//  - Streaming: m_ready=1, send 0x1..0x8 back-to-back.
//      -> m_data 0x1..0x8 on consecutive cycles, 1 cycle latency, s_ready=1 throughout.
//  - Backpressure: m_ready=0, send 0x10, 0x11, 0x12.
//      -> 0x10 and 0x11 accepted, occupancy=2, s_ready=0, 0x12 held upstream.
//      m_ready=1 -> 0x10, 0x11, 0x12 delivered in order.
//  - Simultaneous: BUSY holding 0x20, s_fire(0x21) & m_fire same cycle.
//      -> 0x20 consumed, next cycle m_data=0x21, occupancy=1.
//  - Flush: in FULL (0x30, 0x31), pulse flush with s_valid=1, s_data=0x32.
//      -> next cycle m_valid=0, occupancy=0, s_ready=1, 0x32 never appears on m_data.
//  - Random: random s_valid/m_ready for 10k cycles vs scoreboard queue.
//      -> no loss, duplication or reorder.
//      -> m_data stable whenever m_valid & !m_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid-buffer slice.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_e;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e st);
        case (st)
            BUSY:    occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the skid buffer: registered handshake outputs plus
// the data-register load enables used in the same cycle.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    input  logic             m_ready,
    output logic             main_ld,
    output logic             skid_ld,
    output logic             sel_skid,
    output logic             m_valid,
    output logic             s_ready,
    output logic [OCC_W-1:0] occupancy
);

    skid_state_e state;
    skid_state_e state_nxt;
    logic        s_fire;
    logic        m_fire;

    // Load enables are suppressed under rst/flush so the data regs keep their value.
    always_comb begin
        s_fire    = s_valid & s_ready;
        m_fire    = m_valid & m_ready;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        sel_skid  = 1'b0;
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (s_fire) begin
                    main_ld   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (s_fire && !m_fire) begin
                    skid_ld   = 1'b1;
                    state_nxt = FULL;
                end else if (!s_fire && m_fire) begin
                    state_nxt = EMPTY;
                end else if (s_fire && m_fire) begin
                    main_ld   = 1'b1;
                end
            end
            FULL: begin
                if (m_fire) begin
                    main_ld   = 1'b1;
                    sel_skid  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (rst || flush) begin
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            m_valid   <= 1'b0;
            s_ready   <= 1'b1;
            occupancy <= '0;
        end else begin
            state     <= state_nxt;
            m_valid   <= (state_nxt != EMPTY);
            s_ready   <= (state_nxt != FULL);
            occupancy <= occ_of(state_nxt);
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready register slice: main register drives m_data, skid
// register absorbs the one beat in flight when downstream stalls.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             main_ld;
    logic             skid_ld;
    logic             sel_skid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (s_valid),
        .m_ready   (m_ready),
        .main_ld   (main_ld),
        .skid_ld   (skid_ld),
        .sel_skid  (sel_skid),
        .m_valid   (m_valid),
        .s_ready   (s_ready),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_ld) main_q <= sel_skid ? skid_q : s_data;
            if (skid_ld) skid_q <= s_data;
        end
    end

    assign m_data = main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and random checks of pipe_skid_buffer handshake, ordering and flush.
module tb_pipe_skid_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [1:0]  occupancy;

    int unsigned total = 0;
    int unsigned bad = 0;

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Outputs are observed and inputs changed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 32'hAAAA_AAAA; m_ready = 1'b0;
        step(); step();
        rst = 1'b0; s_valid = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        step();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_m_valid got=%0b exp=0", m_valid); end
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stream_s_ready[%0d] got=%0b exp=1", i, s_ready); end
            step();
            total++; if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
                bad++; $display("FAIL stream_data[%0d] got=%0b/%h exp=1/%h", i, m_valid, m_data, 32'(i));
            end
            total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        s_valid = 1'b0;
        step();
        total++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++; $display("FAIL stream_drain got=%0b/%0d exp=0/0", m_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h10;
        step();
        total++; if (m_data !== 32'h10 || occupancy !== 2'd1 || s_ready !== 1'b1) begin
            bad++; $display("FAIL bp_first got=%h/%0d/%0b exp=10/1/1", m_data, occupancy, s_ready);
        end
        s_data = 32'h11;
        step();
        total++; if (m_data !== 32'h10 || occupancy !== 2'd2 || s_ready !== 1'b0) begin
            bad++; $display("FAIL bp_full got=%h/%0d/%0b exp=10/2/0", m_data, occupancy, s_ready);
        end
        s_data = 32'h12;
        step();
        total++; if (m_data !== 32'h10 || occupancy !== 2'd2 || s_ready !== 1'b0 || m_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold got=%h/%0d/%0b/%0b exp=10/2/0/1", m_data, occupancy, s_ready, m_valid);
        end
        m_ready = 1'b1;
        step();
        total++; if (m_data !== 32'h11 || occupancy !== 2'd1 || s_ready !== 1'b1) begin
            bad++; $display("FAIL bp_pop1 got=%h/%0d/%0b exp=11/1/1", m_data, occupancy, s_ready);
        end
        step();
        total++; if (m_data !== 32'h12 || occupancy !== 2'd1 || m_valid !== 1'b1) begin
            bad++; $display("FAIL bp_pop2 got=%h/%0d/%0b exp=12/1/1", m_data, occupancy, m_valid);
        end
        s_valid = 1'b0;
        step();
        total++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
            bad++; $display("FAIL bp_empty got=%0b/%0d exp=0/0", m_valid, occupancy);
        end
    endtask

    task automatic test_simultaneous();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h20;
        step();
        s_data = 32'h21; m_ready = 1'b1;
        step();
        total++; if (m_valid !== 1'b1 || m_data !== 32'h21 || occupancy !== 2'd1) begin
            bad++; $display("FAIL simul got=%0b/%h/%0d exp=1/21/1", m_valid, m_data, occupancy);
        end
        s_valid = 1'b0;
        step();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL simul_drain got=%0b exp=0", m_valid); end
    endtask

    task automatic test_flush();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h30;
        step();
        s_data = 32'h31;
        step();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_setup got=%0d exp=2", occupancy); end
        flush = 1'b1; s_data = 32'h32;
        step();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        total++; if (m_valid !== 1'b0 || occupancy !== 2'd0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got=%0b/%0d/%0b exp=0/0/1", m_valid, occupancy, s_ready);
        end
        total++; if (m_data !== 32'h30) begin bad++; $display("FAIL flush_data_kept got=%h exp=30", m_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (m_valid !== 1'b0 || m_data === 32'h32) begin
                bad++; $display("FAIL flush_leak[%0d] got=%0b/%h exp=0/not32", i, m_valid, m_data);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic        held;
        logic [31:0] held_data;
        logic [31:0] exp;
        for (int c = 0; c < 10000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = $urandom_range(0, 1) != 0;
            s_data  = $urandom;
            if (c >= 9980) begin s_valid = 1'b0; m_ready = 1'b1; end
            if (m_valid && m_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                total++; if (m_data !== exp) begin
                    bad++; $display("FAIL rand_order[%0d] got=%h exp=%h", c, m_data, exp);
                end
            end
            if (s_valid && s_ready) q.push_back(s_data);
            held = m_valid & ~m_ready;
            held_data = m_data;
            step();
            if (held) begin
                total++; if (m_valid !== 1'b1 || m_data !== held_data) begin
                    bad++; $display("FAIL rand_stable[%0d] got=%0b/%h exp=1/%h", c, m_valid, m_data, held_data);
                end
            end
            total++; if (occupancy !== 2'(q.size()) || m_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rand_occ[%0d] got=%0d/%0b exp=%0d", c, occupancy, m_valid, q.size());
            end
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
